alarm_sequencer: RTL and testbench

- Sequential stage directly downstream of the combinational alarm-condition logic. Consumes its single-bit alarm request L.
- Debounces the request, then runs a timed siren/blink sequence and holds a latched indication until operator acknowledge.
- Counts alarm events for status readout.
- All outputs are registered Moore outputs.

---
 rtl/alarm_sequencer.sv | 107 ++++++++++
 tb/tb_alarm_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// Debounces the alarm request, runs a timed siren/blink sequence, then latches the lamp until acknowledged.
// All outputs are registered Moore outputs; rst clears everything asynchronously.
module alarm_sequencer #(
    parameter int DEB_CYCLES   = 4,
    parameter int ALARM_CYCLES = 16,
    parameter int BLINK_HALF   = 2,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       l_in,
    input  logic       ack,
    output logic       siren,
    output logic       lamp,
    output logic [1:0] state,
    output logic [3:0] alarm_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        ALARM    = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    state_t           st;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] blink;
    logic             go_alarm;

    // A single-cycle debounce lets IDLE jump straight into ALARM.
    assign go_alarm = l_in && (((st == IDLE) && (DEB_CYCLES == 1)) ||
                               ((st == DEBOUNCE) && (deb_cnt == DEB_LAST)));

    assign state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            siren     <= 1'b0;
            lamp      <= 1'b0;
            alarm_cnt <= 4'd0;
            deb_cnt   <= '0;
            timer     <= '0;
            blink     <= '0;
        end else if (go_alarm) begin
            st      <= ALARM;
            siren   <= 1'b1;
            lamp    <= 1'b1;
            timer   <= '0;
            blink   <= '0;
            deb_cnt <= '0;
            if (alarm_cnt != 4'd15)
                alarm_cnt <= alarm_cnt + 4'd1;
        end else begin
            case (st)
                IDLE: begin
                    if (l_in) begin
                        st      <= DEBOUNCE;
                        deb_cnt <= CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!l_in) begin
                        st      <= IDLE;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_W'(1);
                    end
                end
                ALARM: begin
                    // Acknowledge wins over a coincident timeout.
                    if (ack) begin
                        st    <= IDLE;
                        siren <= 1'b0;
                        lamp  <= 1'b0;
                    end else if (timer == ALARM_LAST) begin
                        st    <= HOLD;
                        siren <= 1'b0;
                        lamp  <= 1'b1;
                    end else begin
                        timer <= timer + CNT_W'(1);
                        if (blink == BLINK_LAST) begin
                            blink <= '0;
                            lamp  <= ~lamp;
                        end else begin
                            blink <= blink + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (ack && !l_in) begin
                        st   <= IDLE;
                        lamp <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: vector table, hand-written corner sequences, random run against a model.
module tb_alarm_sequencer;

    localparam int DEB   = 4;
    localparam int ALRM  = 16;
    localparam int BHALF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       l_in;
    logic       ack;
    logic       siren;
    logic       lamp;
    logic [1:0] state;
    logic [3:0] alarm_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: phase, length of the current l_in=1 run, cycles since ALARM entry, alarm count.
    int m_phase, m_streak, m_age, m_count;

    alarm_sequencer #(
        .DEB_CYCLES  (DEB),
        .ALARM_CYCLES(ALRM),
        .BLINK_HALF  (BHALF),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .l_in     (l_in),
        .ack      (ack),
        .siren    (siren),
        .lamp     (lamp),
        .state    (state),
        .alarm_cnt(alarm_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic l;
        logic a;
        int   st;
        int   si;
        int   lp;
        int   cnt;
    } vec_t;

    vec_t tbl[12];

    task automatic model_reset();
        m_phase  = 0;
        m_streak = 0;
        m_age    = 0;
        m_count  = 0;
    endtask

    task automatic model_edge(input logic l, input logic a);
        case (m_phase)
            0, 1: begin
                m_streak = l ? m_streak + 1 : 0;
                if (m_streak == DEB) begin
                    m_phase  = 2;
                    m_age    = 0;
                    m_streak = 0;
                    m_count  = (m_count < 15) ? m_count + 1 : 15;
                end else begin
                    m_phase = (m_streak > 0) ? 1 : 0;
                end
            end
            2: begin
                if (a)                     m_phase = 0;
                else if (m_age + 1 == ALRM) m_phase = 3;
                else                       m_age = m_age + 1;
            end
            default: begin
                if (a && !l) m_phase = 0;
            end
        endcase
    endtask

    function automatic int model_lamp();
        if (m_phase == 3) return 1;
        if (m_phase == 2) return (((m_age / BHALF) % 2) == 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_all(input string name, input int st, input int si, input int lp, input int cnt);
        chk({name, ".state"}, int'(state), st);
        chk({name, ".siren"}, int'(siren), si);
        chk({name, ".lamp"},  int'(lamp),  lp);
        chk({name, ".cnt"},   int'(alarm_cnt), cnt);
    endtask

    task automatic step(input logic l, input logic a);
        l_in = l;
        ack  = a;
        @(posedge clk);
        model_edge(l, a);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        l_in = 1'b0;
        ack  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic trigger();
        repeat (DEB) step(1'b1, 1'b0);
    endtask

    initial begin
        rst  = 1'b1;
        l_in = 1'b0;
        ack  = 1'b0;
        model_reset();
        #12;
        chk_all("reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Short pulse, ignored ack in debounce, full debounce, blink start, ack exit, re-debounce.
        tbl[0]  = '{1'b1, 1'b0, 1, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1, 0, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 0, 0, 0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1, 0, 0, 0};
        tbl[5]  = '{1'b1, 1'b0, 1, 0, 0, 0};
        tbl[6]  = '{1'b1, 1'b0, 1, 0, 0, 0};
        tbl[7]  = '{1'b1, 1'b0, 2, 1, 1, 1};
        tbl[8]  = '{1'b1, 1'b0, 2, 1, 1, 1};
        tbl[9]  = '{1'b0, 1'b0, 2, 1, 0, 1};
        tbl[10] = '{1'b0, 1'b1, 0, 0, 0, 1};
        tbl[11] = '{1'b1, 1'b0, 1, 0, 0, 1};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].l, tbl[i].a);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].si, tbl[i].lp, tbl[i].cnt);
        end

        // Full timeout: siren for exactly ALRM cycles with 1,1,0,0 lamp pattern, then HOLD.
        do_reset();
        trigger();
        chk_all("entry", 2, 1, 1, 1);
        for (int k = 1; k < ALRM; k++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            chk_all($sformatf("blink%0d", k), 2, 1, (((k / BHALF) % 2) == 0) ? 1 : 0, 1);
        end
        step(1'b1, 1'b0);
        chk_all("timeout", 3, 0, 1, 1);
        step(1'b1, 1'b1);
        chk_all("hold_ack_l1", 3, 0, 1, 1);
        step(1'b0, 1'b1);
        chk_all("hold_exit", 0, 0, 0, 1);

        // Ack on the fifth ALARM cycle, then ack exactly on the timeout edge.
        trigger();
        repeat (4) step(1'b0, 1'b0);
        chk("pre_ack.state", int'(state), 2);
        step(1'b0, 1'b1);
        chk_all("ack5", 0, 0, 0, 2);
        trigger();
        repeat (ALRM - 1) step(1'b0, 1'b0);
        chk("pre_to.siren", int'(siren), 1);
        step(1'b0, 1'b1);
        chk_all("ack_timeout", 0, 0, 0, 3);

        // Asynchronous reset between edges while in ALARM.
        trigger();
        repeat (3) step(1'b0, 1'b0);
        chk("pre_rst.siren", int'(siren), 1);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Counter saturation over 17 alarms.
        for (int i = 0; i < 17; i++) begin
            trigger();
            chk($sformatf("sat%0d", i), int'(alarm_cnt), (i + 1 > 15) ? 15 : i + 1);
            step(1'b0, 1'b1);
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 8));
            chk_all($sformatf("rnd%0d", i), m_phase, (m_phase == 2) ? 1 : 0, model_lamp(), m_count);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
